// File: rtl/load_sequencer.sv
// Load sequencer: buffers load requests in a FIFO and issues them to the counter as one-cycle
// load pulses, either immediately or on a terminal match. Optional flush port: LOAD_SEQ_FLUSH_EN.
`timescale 1ns/1ps
module load_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef LOAD_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_value,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] term_value,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             load,
  output logic [WIDTH-1:0] load_value,
  output logic             busy,
  output logic [7:0]       issued_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, FIRE} state_t;

  state_t          state, state_nxt;
  logic [AW:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [WIDTH:0]  mem [DEPTH];
  logic            full, empty, push, pop, do_flush, match;
  logic            head_mode;
  logic [WIDTH-1:0] head_value;

`ifdef LOAD_SEQ_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Extra wrap bit distinguishes full from empty when the index bits coincide.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  assign req_ready = !full;
  assign push      = req_valid && !full && !do_flush;
  assign {head_mode, head_value} = mem[rd_ptr[AW-1:0]];
  assign match     = (cnt_in == term_value);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (!head_mode || match) begin
            pop       = 1'b1;
            state_nxt = FIRE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // A waiting mode-1 head blocks everything behind it until its match.
        if (match) begin
          pop       = 1'b1;
          state_nxt = FIRE;
        end
      end
      FIRE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The load of a FIRE already on the outputs still completes; nothing new is popped.
    if (do_flush) begin
      pop       = 1'b0;
      state_nxt = IDLE;
    end
  end

  assign wr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt = do_flush ? wr_ptr : rd_ptr + {{AW{1'b0}}, pop};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      load         <= 1'b0;
      load_value   <= '0;
      busy         <= 1'b0;
      issued_count <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      load   <= pop;
      if (pop) begin
        load_value   <= head_value;
        issued_count <= issued_count + 8'd1;
      end
      // Reflects the occupancy and state being entered on this edge.
      busy <= (wr_nxt != rd_nxt) || (state_nxt != IDLE);
    end
  end

  // NOTE: the storage array has no reset; entries are only read once the pointers say they were written.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {req_mode, req_value};
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Scoreboard bench for load_sequencer: a behavioural FIFO-of-requests model predicts every load
// pulse; a tb-side loadable counter closes the cnt_in feedback loop.
`timescale 1ns/1ps
module tb_load_sequencer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             req_valid, req_ready, req_mode;
  logic [WIDTH-1:0] req_value, term_value, cnt, load_value;
  logic             load, busy;
  logic [7:0]       issued_count;
  logic             cnt_run;
`ifdef LOAD_SEQ_FLUSH_EN
  logic             flush = 1'b0;
`endif

  typedef struct {
    bit               mode;
    logic [WIDTH-1:0] value;
  } req_t;

  req_t sb[$];
  int   load_times[$];
  int   accept_times[$];
  int   cyc;
  int   n_checks;
  int   n_errors;

  load_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef LOAD_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_value(req_value),
    .req_mode(req_mode),
    .term_value(term_value),
    .cnt_in(cnt),
    .load(load),
    .load_value(load_value),
    .busy(busy),
    .issued_count(issued_count)
  );

  always #5 CLK = ~CLK;

  // Downstream loadable up-counter.
  always @(posedge CLK) begin
    if (!RST)          cnt <= '0;
    else if (load)     cnt <= load_value;
    else if (cnt_run)  cnt <= cnt + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: each negedge first applies the previous rising edge to the model, then compares.
  initial begin
    logic             c_rst = 1'b0, c_valid = 1'b0, c_mode = 1'b0, c_match = 1'b0;
    logic [WIDTH-1:0] c_value = '0;
    logic [WIDTH-1:0] model_lv = '0;
    logic             prev_load = 1'b0;
    int               loads = 0;
    bit               rst_edge;
    req_t             e;
    forever begin
      @(negedge CLK);
      cyc++;
      rst_edge = !c_rst;
      if (rst_edge) begin
        sb.delete();
        loads    = 0;
        model_lv = '0;
      end else if (c_valid && sb.size() < DEPTH) begin
        sb.push_back('{c_mode, c_value});
        accept_times.push_back(cyc);
      end
      if (rst_edge) begin
        check("rst_load", load, 0);
        check("rst_load_value", load_value, 0);
        check("rst_busy", busy, 0);
        check("rst_issued", issued_count, 0);
        check("rst_ready", req_ready, 1);
      end else begin
        if (load) begin
          check("load_spacing", prev_load, 0);
          if (sb.size() == 0) begin
            check("load_unexpected", load, 0);
          end else begin
            e = sb.pop_front();
            check("load_value", load_value, e.value);
            if (e.mode) check("term_match", c_match, 1);
            model_lv = e.value;
          end
          loads++;
          load_times.push_back(cyc);
        end else begin
          check("load_hold", load_value, model_lv);
        end
        check("issued_count", issued_count, loads % 256);
        check("req_ready", req_ready, sb.size() != DEPTH);
        check("busy", busy, (sb.size() != 0) || load);
      end
      prev_load = rst_edge ? 1'b0 : load;
      c_rst   = RST;
      c_valid = req_valid;
      c_mode  = req_mode;
      c_value = req_value;
      c_match = (cnt == term_value);
    end
  end

  task automatic push(input bit mode, input logic [WIDTH-1:0] v);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_mode  = mode;
    req_value = v;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge CLK);
      acc = req_ready;
      @(posedge CLK);
      #1;
    end
    check("push_accept", acc, 1);
  endtask

  task automatic wait_drain(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    check("drain", done, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    load_times.delete();
    accept_times.delete();
  endtask

  task automatic pulse_reset(input int cycles);
    RST = 1'b0;
    repeat (cycles) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    bit fired;
    RST        = 1'b0;
    req_valid  = 1'b1;
    req_mode   = 1'b0;
    req_value  = 4'd5;
    term_value = '0;
    cnt_run    = 1'b1;

    // Reset with a request presented: nothing may be accepted.
    repeat (2) @(posedge CLK);
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_load", load, 0);
    check("reset_busy", busy, 0);
    check("reset_issued", issued_count, 0);
    RST       = 1'b1;
    req_valid = 1'b0;
    clear_log();
    repeat (4) @(posedge CLK);
    #1;
    check("reset_no_loads", load_times.size(), 0);
    check("reset_idle_busy", busy, 0);

    // Immediate loads back-to-back.
    clear_log();
    push(1'b0, 4'd3);
    push(1'b0, 4'd7);
    push(1'b0, 4'd12);
    req_valid = 1'b0;
    wait_drain(50);
    check("imm_loads", load_times.size(), 3);
    check("imm_issued", issued_count, 3);
    if (load_times.size() == 3) begin
      check("imm_latency", load_times[0] - accept_times[0], 1);
      check("imm_gap1", load_times[1] - load_times[0], 2);
      check("imm_gap2", load_times[2] - load_times[1], 2);
    end

    // Terminal mode with a free-running counter from 0.
    term_value = 4'd9;
    pulse_reset(1);
    clear_log();
    push(1'b1, 4'd2);
    req_valid = 1'b0;
    fired = 1'b0;
    for (int i = 0; i < 100 && !fired; i++) begin
      @(negedge CLK);
      #1;
      fired = load;
    end
    check("term_fired", fired, 1);
    @(negedge CLK);
    #1;
    check("term_cnt_after", cnt, 2);
    @(negedge CLK);
    #1;
    check("term_cnt_next", cnt, 3);
    wait_drain(50);

    // Head-of-line blocking.
    clear_log();
    term_value = 4'd15;
    push(1'b1, 4'd4);
    push(1'b0, 4'd1);
    req_valid = 1'b0;
    wait_drain(100);
    check("hol_loads", load_times.size(), 2);
    if (load_times.size() == 2) check("hol_gap", load_times[1] - load_times[0], 2);

    // Backpressure: counter frozen so the mode-1 head never matches.
    cnt_run = 1'b0;
    @(posedge CLK);
    #1;
    term_value = cnt ^ 4'h1;
    clear_log();
    req_valid = 1'b1;
    req_mode  = 1'b1;
    req_value = 4'd6;
    repeat (5) @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check("full_ready", req_ready, 0);
    check("full_busy", busy, 1);
    check("full_no_loads", load_times.size(), 0);
    cnt_run = 1'b1;
    wait_drain(200);
    check("full_loads", load_times.size(), 4);

    // Reset while waiting with three entries queued.
    cnt_run = 1'b0;
    @(posedge CLK);
    #1;
    term_value = cnt ^ 4'h1;
    for (int i = 0; i < 3; i++) push(1'b1, 4'd9);
    req_valid = 1'b0;
    @(negedge CLK);
    #1;
    check("mid_wait_busy", busy, 1);
    @(posedge CLK);
    #1;
    pulse_reset(2);
    clear_log();
    term_value = '0;
    cnt_run    = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    check("flushed_no_loads", load_times.size(), 0);
    check("flushed_busy", busy, 0);

    // issued_count wraps after 256 loads.
    clear_log();
    for (int i = 0; i < 256; i++) push(1'b0, WIDTH'($urandom));
    req_valid = 1'b0;
    wait_drain(100);
    check("wrap_loads", load_times.size(), 256);
    check("wrap_issued", issued_count, 0);

    // Randomized traffic.
    clear_log();
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_mode  = 1'($urandom_range(0, 1));
      req_value = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) term_value = WIDTH'($urandom);
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    wait_drain(300);
    check("rand_all_issued", load_times.size(), accept_times.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
Upstream stage of the loadable up-counter. Accepts load requests over a valid/ready interface and buffers them in a small FIFO. Issues each request to the counter as a one-cycle load pulse with a value, either immediately or when the counter's current value reaches a programmed terminal value. Its load_value/load outputs drive the counter's load data and load strobe; the counter's count output feeds back into cnt_in.

Parameters:
WIDTH, 4, width of counter value, request value, terminal value
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  FIFO can accept; combinational = !full
req_value  input  WIDTH  value to load into counter
req_mode  input  1  0 = fire immediately, 1 = fire when cnt_in == term_value
term_value  input  WIDTH  terminal compare value, sampled live
cnt_in  input  WIDTH  current counter value (counter output)
load  output  1  registered load strobe to counter
load_value  output  WIDTH  registered load data to counter
busy  output  1  registered; 1 when FIFO non-empty or state != IDLE
issued_count  output  8  registered count of loads issued, wraps 255->0

Behaviour:
- Reset (RST==0 at a rising edge): FIFO empty, state IDLE, load=0, load_value=0, busy=0, issued_count=0. Reset overrides all other activity, including a pending WAIT or FIRE; any buffered requests are discarded.
- Push: on an edge with req_valid && req_ready, {req_mode, req_value} is written at the tail.
- req_ready depends only on full. A push is refused when full even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: both occur; occupancy is unchanged.
- FSM states: IDLE, WAIT, FIRE.
- IDLE:
  - FIFO empty: stay in IDLE.
  - Head mode 0: pop, go to FIRE.
  - Head mode 1 and cnt_in == term_value this cycle: pop, go to FIRE.
  - Head mode 1, no match: go to WAIT.
- WAIT: each cycle compare cnt_in == term_value. On match, pop and go to FIRE; otherwise stay. A mode-1 head is never skipped; it blocks later entries.
- FIRE: lasts exactly one cycle.
  - load=1; load_value = popped value, stable for that cycle.
  - issued_count increments on entry to FIRE.
  - Next state is IDLE, with the same head evaluation applied the following cycle.
- Issue rate: the mandatory FIRE/IDLE pass gives at most one load per 2 cycles, so the counter's registered output reflects the new value before the next compare.
- Latency, mode 0, from empty: request accepted at edge N; load high in the cycle after edge N+1 (2 edges).
- Latency, mode 1: load high in the cycle after the first edge at which the entry is head and cnt_in == term_value.
- load is 0 in every state except FIRE. load_value holds its last value when load=0.
- busy = (FIFO non-empty) || (state != IDLE), registered, updated each edge.
- Pointers are log2(DEPTH) bits plus a wrap bit.
  - full: pointers equal, wrap bits differ.
  - empty: pointers and wrap bits equal.
- Pop on empty cannot occur by construction; push on full is ignored.

Optional Feature:
LOAD_SEQ_FLUSH_EN
- Defined: adds input port flush (1 bit). On an edge with flush=1 (and RST=1):
  - FIFO is emptied and any push in that cycle is dropped.
  - WAIT goes to IDLE.
  - A FIRE in progress still completes its single load cycle, then goes to IDLE.
  - issued_count is unaffected.
- Undefined: no flush port; the FIFO drains only by issuing loads.

Test Plan:
- Reset: RST=0 for 2 cycles with req_valid=1 -> load=0, load_value=0, busy=0, issued_count=0, no entries accepted; after RST=1, req_ready=1.
- Immediate loads: push values 3,7,12 (mode 0) back-to-back -> three load pulses with values 3,7,12, each separated by exactly one idle cycle; issued_count=3; first pulse 2 edges after first accept.
- Terminal mode: counter free-running from 0, term_value=9, push value 2 mode 1 -> load asserted in the cycle after cnt_in==9 is sampled, load_value=2; the counter then counts 2,3,...
- Full/backpressure: DEPTH=4, hold the head in WAIT (term_value never reached), push 5 requests -> 4 accepted, req_ready=0 on the 5th; busy=1; no load pulses.
- Head-of-line blocking: push mode-1 value 4 (term 15) then mode-0 value 1 -> no load until cnt_in==15, then loads 4 then 1 on consecutive FIRE slots.
- Reset mid-WAIT with 3 entries queued, and issued_count wrap -> queue cleared, no load after reset; separately, 256 immediate loads -> issued_count returns to 0.
